// File: rtl/mips_ctrl_alu_branch_if.sv
// rtl/mips_ctrl_alu_branch_if.sv - decode/execute bus between the pipeline and the decode/ALU/branch core
interface mips_ctrl_alu_branch_if;
    logic [6:0]  opcode;
    logic        skip_w;
    logic        wr;
    logic        pop;
    logic        push;
    logic        skip_m;
    logic [2:0]  func;
    logic        skip_e;
    logic [2:0]  branch;
    logic        set_c;
    logic        load;
    logic        imm2;
    logic        imm1;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  ex_func;
    logic        ex_skip_e;
    logic        ex_set_c;
    logic [2:0]  ex_branch;
    logic        ex_valid;
    logic [15:0] r;
    logic        z;
    logic        n;
    logic        c;
    logic        zf;
    logic        nf;
    logic        cf;
    logic        jump;

    modport slave (
        input  opcode, a, b, ex_func, ex_skip_e, ex_set_c, ex_branch, ex_valid,
        output skip_w, wr, pop, push, skip_m, func, skip_e, branch, set_c, load,
               imm2, imm1, r, z, n, c, zf, nf, cf, jump
    );

    modport master (
        output opcode, a, b, ex_func, ex_skip_e, ex_set_c, ex_branch, ex_valid,
        input  skip_w, wr, pop, push, skip_m, func, skip_e, branch, set_c, load,
               imm2, imm1, r, z, n, c, zf, nf, cf, jump
    );
endinterface

// File: rtl/mips_ctrl_alu_branch.sv
// rtl/mips_ctrl_alu_branch.sv - ID opcode decoder, EX ALU, registered Z/N/C flags and branch resolution
module mips_ctrl_alu_branch (
    input  logic                       clk,
    input  logic                       rst,
    mips_ctrl_alu_branch_if.slave      bus
);
    localparam logic [2:0] F_ADD = 3'b000;
    localparam logic [2:0] F_SUB = 3'b001;
    localparam logic [2:0] F_AND = 3'b010;
    localparam logic [2:0] F_OR  = 3'b011;
    localparam logic [2:0] F_NOT = 3'b100;
    localparam logic [2:0] F_SHL = 3'b101;
    localparam logic [2:0] F_SHR = 3'b110;
    localparam logic [2:0] F_MOV = 3'b111;

    logic        skip_w, wr, pop, push, skip_m, skip_e, set_c, load, imm2, imm1;
    logic [2:0]  func, branch;

    always_comb begin
        skip_w = 1'b1;
        wr     = 1'b0;
        pop    = 1'b0;
        push   = 1'b0;
        skip_m = 1'b1;
        func   = 3'b000;
        skip_e = 1'b1;
        branch = 3'b000;
        set_c  = 1'b0;
        load   = 1'b0;
        imm2   = 1'b0;
        imm1   = 1'b0;
        if (bus.opcode[6:3] == 4'b0001) begin
            func   = bus.opcode[2:0];
            skip_e = 1'b0;
            skip_w = 1'b0;
            imm2   = (bus.opcode[2:0] == F_SHL) || (bus.opcode[2:0] == F_SHR);
        end else begin
            case (bus.opcode)
                7'h01: set_c = 1'b1;
                7'h10: begin func = F_MOV; imm2 = 1'b1; skip_w = 1'b0; end
                7'h11: begin func = F_ADD; imm2 = 1'b1; skip_e = 1'b0; skip_w = 1'b0; end
                7'h18: begin skip_m = 1'b0; load = 1'b1; skip_w = 1'b0; end
                7'h19: begin skip_m = 1'b0; wr = 1'b1; end
                7'h1A: begin skip_m = 1'b0; push = 1'b1; wr = 1'b1; end
                7'h1B: begin skip_m = 1'b0; pop = 1'b1; load = 1'b1; skip_w = 1'b0; end
                7'h20: begin branch = 3'b001; imm1 = 1'b1; end
                7'h21: begin branch = 3'b010; imm1 = 1'b1; end
                7'h22: begin branch = 3'b011; imm1 = 1'b1; end
                7'h23: begin branch = 3'b100; imm1 = 1'b1; end
                default: ;
            endcase
        end
    end

    // 17-bit intermediates: bit 16 of add/sub is carry/borrow, the spare bit of each shift catches the last bit shifted out
    logic [3:0]  shamt;
    logic [16:0] sum, diff, shl, shr;
    logic [15:0] r;
    logic        c;

    assign shamt = bus.b[3:0];
    assign sum   = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff  = {1'b0, bus.a} - {1'b0, bus.b};
    assign shl   = {1'b0, bus.a} << shamt;
    assign shr   = {bus.a, 1'b0} >> shamt;

    always_comb begin
        r = 16'h0000;
        c = 1'b0;
        case (bus.ex_func)
            F_ADD: begin r = sum[15:0];  c = sum[16];  end
            F_SUB: begin r = diff[15:0]; c = diff[16]; end
            F_AND: r = bus.a & bus.b;
            F_OR:  r = bus.a | bus.b;
            F_NOT: r = ~bus.a;
            F_SHL: begin r = shl[15:0];  c = shl[16];  end
            F_SHR: begin r = shr[16:1];  c = shr[0];   end
            F_MOV: r = bus.b;
            default: ;
        endcase
    end

    logic zf_q, nf_q, cf_q;
    logic zf_d, nf_d, cf_d;
    logic carry_func;

    assign carry_func = (bus.ex_func == F_ADD) || (bus.ex_func == F_SUB) ||
                        (bus.ex_func == F_SHL) || (bus.ex_func == F_SHR);

    always_comb begin
        zf_d = zf_q;
        nf_d = nf_q;
        cf_d = cf_q;
        if (bus.ex_valid) begin
            if (!bus.ex_skip_e) begin
                zf_d = (r == 16'h0000);
                nf_d = r[15];
                if (carry_func) cf_d = c;
            end
            if (bus.ex_set_c) cf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zf_q <= 1'b0;
            nf_q <= 1'b0;
            cf_q <= 1'b0;
        end else begin
            zf_q <= zf_d;
            nf_q <= nf_d;
            cf_q <= cf_d;
        end
    end

    // Branches see the flags as they were before the instruction now in EX
    logic jump;
    always_comb begin
        jump = 1'b0;
        case (bus.ex_branch)
            3'b001: jump = 1'b1;
            3'b010: jump = zf_q;
            3'b011: jump = nf_q;
            3'b100: jump = cf_q;
            default: jump = 1'b0;
        endcase
        jump = jump & bus.ex_valid;
    end

    assign bus.skip_w = skip_w;
    assign bus.wr     = wr;
    assign bus.pop    = pop;
    assign bus.push   = push;
    assign bus.skip_m = skip_m;
    assign bus.func   = func;
    assign bus.skip_e = skip_e;
    assign bus.branch = branch;
    assign bus.set_c  = set_c;
    assign bus.load   = load;
    assign bus.imm2   = imm2;
    assign bus.imm1   = imm1;
    assign bus.r      = r;
    assign bus.z      = (r == 16'h0000);
    assign bus.n      = r[15];
    assign bus.c      = c;
    assign bus.zf     = zf_q;
    assign bus.nf     = nf_q;
    assign bus.cf     = cf_q;
    assign bus.jump   = jump;
endmodule

// File: tb/tb_mips_ctrl_alu_branch.sv
// tb/tb_mips_ctrl_alu_branch.sv - directed self-checking bench for mips_ctrl_alu_branch
module tb_mips_ctrl_alu_branch;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mips_ctrl_alu_branch_if bus ();

    mips_ctrl_alu_branch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    // {skip_w, wr, pop, push, skip_m, func[2:0], skip_e, branch[2:0], set_c, load, imm2, imm1}
    function automatic logic [15:0] dec_vec();
        return {bus.skip_w, bus.wr, bus.pop, bus.push, bus.skip_m, bus.func, bus.skip_e,
                bus.branch, bus.set_c, bus.load, bus.imm2, bus.imm1};
    endfunction

    function automatic logic [15:0] flags();
        return {13'd0, bus.zf, bus.nf, bus.cf};
    endfunction

    task automatic ex(input logic valid, input logic [2:0] f, input logic [15:0] a, input logic [15:0] b,
                      input logic skip_e, input logic set_c, input logic [2:0] br);
        bus.ex_valid  = valid;
        bus.ex_func   = f;
        bus.a         = a;
        bus.b         = b;
        bus.ex_skip_e = skip_e;
        bus.ex_set_c  = set_c;
        bus.ex_branch = br;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct { logic [6:0] op; logic [15:0] exp; } dec_t;
    typedef struct { logic [2:0] f; logic [15:0] a; logic [15:0] b; logic [15:0] r; logic [2:0] znc; } alu_t;

    dec_t dec_tab[14] = '{
        '{7'h00, 16'h8880}, '{7'h01, 16'h8888}, '{7'h08, 16'h0800}, '{7'h0D, 16'h0D02},
        '{7'h0E, 16'h0E02}, '{7'h10, 16'h0F82}, '{7'h11, 16'h0802}, '{7'h18, 16'h0084},
        '{7'h19, 16'hC080}, '{7'h1A, 16'hD080}, '{7'h1B, 16'h2084}, '{7'h22, 16'h88B1},
        '{7'h7F, 16'h8880}, '{7'h48, 16'h8880}
    };

    alu_t alu_tab[12] = '{
        '{3'b000, 16'hFFFF, 16'h0001, 16'h0000, 3'b101},
        '{3'b001, 16'h0003, 16'h0005, 16'hFFFE, 3'b011},
        '{3'b101, 16'h8001, 16'h0001, 16'h0002, 3'b001},
        '{3'b110, 16'h0003, 16'h0001, 16'h0001, 3'b001},
        '{3'b101, 16'h1234, 16'h0000, 16'h1234, 3'b000},
        '{3'b110, 16'h8000, 16'h000F, 16'h0001, 3'b000},
        '{3'b010, 16'hF0F0, 16'h0FF0, 16'h00F0, 3'b000},
        '{3'b011, 16'h0F00, 16'h00F0, 16'h0FF0, 3'b000},
        '{3'b100, 16'h00FF, 16'h1234, 16'hFF00, 3'b010},
        '{3'b111, 16'h0001, 16'h8000, 16'h8000, 3'b010},
        '{3'b001, 16'h0005, 16'h0005, 16'h0000, 3'b100},
        '{3'b000, 16'h7FFF, 16'h0001, 16'h8000, 3'b010}
    };

    initial begin
        rst = 1'b1;
        bus.opcode = 7'h00;
        ex(1'b0, 3'b000, 16'h0, 16'h0, 1'b1, 1'b0, 3'b000);
        tick();
        tick();
        check("reset_flags", flags(), 16'h0000);
        rst = 1'b0;

        foreach (dec_tab[i]) begin
            bus.opcode = dec_tab[i].op;
            #1;
            check($sformatf("decode_%02h", dec_tab[i].op), dec_vec(), dec_tab[i].exp);
        end

        foreach (alu_tab[i]) begin
            ex(1'b0, alu_tab[i].f, alu_tab[i].a, alu_tab[i].b, 1'b1, 1'b0, 3'b000);
            #1;
            check($sformatf("alu_r_%0d", i), bus.r, alu_tab[i].r);
            check($sformatf("alu_znc_%0d", i), {13'd0, bus.z, bus.n, bus.c}, {13'd0, alu_tab[i].znc});
        end

        // flags: {zf, nf, cf}
        ex(1'b1, 3'b001, 16'h0005, 16'h0005, 1'b0, 1'b0, 3'b000); tick();
        check("flags_sub_eq", flags(), 16'h0004);
        ex(1'b1, 3'b000, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 3'b000); tick();
        check("flags_add_carry", flags(), 16'h0005);
        ex(1'b1, 3'b010, 16'hF0F0, 16'h0FF0, 1'b0, 1'b0, 3'b000); tick();
        check("flags_and_keeps_c", flags(), 16'h0001);
        ex(1'b1, 3'b001, 16'h0005, 16'h0005, 1'b1, 1'b0, 3'b000); tick();
        check("flags_skip_e_hold", flags(), 16'h0001);
        ex(1'b0, 3'b001, 16'h0005, 16'h0005, 1'b0, 1'b1, 3'b001); #1;
        check("jump_invalid_jmp", {15'd0, bus.jump}, 16'h0000);
        tick();
        check("flags_invalid_hold", flags(), 16'h0001);

        ex(1'b1, 3'b001, 16'h0005, 16'h0005, 1'b0, 1'b0, 3'b000); tick();
        check("flags_clear_c", flags(), 16'h0004);
        ex(1'b1, 3'b010, 16'h0000, 16'h0000, 1'b1, 1'b1, 3'b000); tick();
        check("flags_setc", flags(), 16'h0005);
        ex(1'b1, 3'b001, 16'h0005, 16'h0003, 1'b0, 1'b1, 3'b000); tick();
        check("flags_setc_override", flags(), 16'h0001);

        // zf=0 nf=0 cf=1; EX inputs with skip_e=1 leave flags alone
        ex(1'b1, 3'b000, 16'h0, 16'h0, 1'b1, 1'b0, 3'b100); #1;
        check("jump_jc", {15'd0, bus.jump}, 16'h0001);
        ex(1'b0, 3'b000, 16'h0, 16'h0, 1'b1, 1'b0, 3'b100); #1;
        check("jump_jc_invalid", {15'd0, bus.jump}, 16'h0000);
        ex(1'b1, 3'b000, 16'h0, 16'h0, 1'b1, 1'b0, 3'b010); #1;
        check("jump_jz_zf0", {15'd0, bus.jump}, 16'h0000);
        ex(1'b1, 3'b000, 16'h0, 16'h0, 1'b1, 1'b0, 3'b011); #1;
        check("jump_jn_nf0", {15'd0, bus.jump}, 16'h0000);
        ex(1'b1, 3'b000, 16'h0, 16'h0, 1'b1, 1'b0, 3'b001); #1;
        check("jump_jmp", {15'd0, bus.jump}, 16'h0001);
        for (int k = 5; k <= 7; k++) begin
            ex(1'b1, 3'b000, 16'h0, 16'h0, 1'b1, 1'b0, 3'(k)); #1;
            check($sformatf("jump_code_%0d", k), {15'd0, bus.jump}, 16'h0000);
        end
        ex(1'b1, 3'b000, 16'h0, 16'h0, 1'b1, 1'b0, 3'b000); #1;
        check("jump_code_0", {15'd0, bus.jump}, 16'h0000);
        tick();

        ex(1'b1, 3'b111, 16'h0000, 16'h8000, 1'b0, 1'b0, 3'b000); tick();
        check("flags_mov_neg", flags(), 16'h0003);
        ex(1'b1, 3'b000, 16'h0, 16'h0, 1'b1, 1'b0, 3'b011); #1;
        check("jump_jn_nf1", {15'd0, bus.jump}, 16'h0001);
        tick();

        // JZ alongside a zero-producing op sees the old zf, then the new one
        ex(1'b1, 3'b001, 16'h0005, 16'h0005, 1'b0, 1'b0, 3'b010); #1;
        check("jump_jz_old_flag", {15'd0, bus.jump}, 16'h0000);
        tick();
        check("jump_jz_new_flag", {15'd0, bus.jump}, 16'h0001);
        check("flags_before_reset", flags(), 16'h0004);

        rst = 1'b1;
        ex(1'b1, 3'b000, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 3'b001); #1;
        check("jump_during_reset", {15'd0, bus.jump}, 16'h0001);
        tick();
        check("flags_reset_over_update", flags(), 16'h0000);
        rst = 1'b0;
        ex(1'b1, 3'b000, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 3'b000); tick();
        check("flags_after_reset", flags(), 16'h0005);
        rst = 1'b1;
        ex(1'b0, 3'b000, 16'h0, 16'h0, 1'b1, 1'b0, 3'b000); tick();
        check("flags_reset_clear", flags(), 16'h0000);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_ctrl_alu_branch.md
# mips_ctrl_alu_branch

Decode/execute core of the 16-bit pipelined MIPS-style CPU. It combines three parts:
- a combinational opcode decoder that produces WB, MEM, EX and source/branch control fields;
- a 16-bit ALU that returns a result plus Z/N/C;
- the registered Z/N/C flag register and the branch-resolution logic.

The decoder sits in ID; the ALU, flag register and branch logic sit in EX.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- opcode  in  7  ID-stage instruction bits [6:0].
- skip_w  out  1  no register write-back.
- wr  out  1  memory write.
- pop  out  1  stack pop.
- push  out  1  stack push.
- skip_m  out  1  no memory access.
- func  out  3  ALU function.
- skip_e  out  1  no ALU flag update.
- branch  out  3  branch code.
- set_c  out  1  set carry.
- load  out  1  WB data comes from memory.
- imm2  out  1  ALU operand b comes from the immediate.
- imm1  out  1  ALU operand a comes from the immediate.
- a, b  in  16  EX operands, already muxed.
- ex_func  in  3  EX-stage func.
- ex_skip_e  in  1  EX-stage skip_e.
- ex_set_c  in  1  EX-stage set_c.
- ex_branch  in  3  EX-stage branch code.
- ex_valid  in  1  EX stage holds a real (non-bubble) instruction.
- r  out  16  ALU result.
- z, n, c  out  1 each  raw ALU flags.
- zf, nf, cf  out  1 each  registered flags.
- jump  out  1  redirect PC to the branch target.

## Operation
- Decoder: purely combinational. Every opcode not listed below decodes exactly as NOP.
- Default outputs: all zero except skip_w=1, skip_m=1, skip_e=1.
- 0x00 NOP: defaults.
- 0x01 SETC: defaults plus set_c=1.
- 0x08–0x0F, register ALU ops: func = opcode[2:0] (ADD, SUB, AND, OR, NOT, SHL, SHR, MOV); skip_e=0; skip_w=0.
  - SHL (0x0D) and SHR (0x0E) additionally set imm2=1.
- 0x10 LDM: func=111, imm2=1, skip_w=0.
- 0x11 IADD: func=000, imm2=1, skip_e=0, skip_w=0.
- 0x18 LDD: skip_m=0, load=1, skip_w=0.
- 0x19 STD: skip_m=0, wr=1.
- 0x1A PUSH: skip_m=0, push=1, wr=1.
- 0x1B POP: skip_m=0, pop=1, load=1, skip_w=0.
- 0x20/0x21/0x22/0x23 JMP/JZ/JN/JC: branch=001/010/011/100, imm1=1.
- ALU (combinational, modulo 2^16):
  - 000 ADD: r=a+b, c=carry-out of bit 15.
  - 001 SUB: r=a−b, c=1 iff a<b unsigned (borrow).
  - 010 AND, 011 OR: r=a&b, r=a|b.
  - 100 NOT: r=~a.
  - 101 SHL: r=a<<b[3:0]; c=a[16−s] when s=b[3:0]≠0, else 0.
  - 110 SHR: r=a>>b[3:0] (logical); c=a[s−1] when s≠0, else 0.
  - 111 MOV: r=b.
  - z=(r==0) and n=r[15] for every func. c=0 for AND/OR/NOT/MOV.
- Flag register: loads on the clock edge only when ex_valid=1.
  - If ex_skip_e=0: zf<=z and nf<=n. cf<=c for ADD/SUB/SHL/SHR; cf is held for AND/OR/NOT/MOV.
  - If ex_set_c=1: cf<=1. This overrides the ALU carry.
  - If ex_skip_e=1 and ex_set_c=0: all flags hold.
- Branch (combinational) uses the registered flags, i.e. the values before the current EX instruction updates them:
  - jump = ex_valid & (ex_branch==001 | (ex_branch==010 & zf) | (ex_branch==011 & nf) | (ex_branch==100 & cf)).
  - Codes 000 and 101–111 never jump.

## Timing
- The decoder, ALU and jump have zero latency.
- Flags update one clk edge after the EX inputs are presented.
- Reset: while rst=1 at a rising edge, zf=nf=cf=0. Reset has priority over any flag update.
  - Combinational outputs follow their inputs during reset. jump may still assert if ex_branch=001 and ex_valid=1.
- A JZ/JN/JC in EX the cycle after an ALU op sees the flags produced by that ALU op (they have already been clocked in).
- ex_valid=0 freezes the flags and forces jump=0, regardless of the other EX inputs.

## Test plan
- Decode sweep: opcode 0x08 -> func=000, skip_e=0, skip_w=0, skip_m=1. Opcode 0x1A -> push=1, wr=1, skip_m=0, skip_w=1. Opcode 0x7F -> NOP defaults.
- ALU: ADD 0xFFFF+0x0001 -> r=0, z=1, c=1. SUB 0x0003−0x0005 -> r=0xFFFE, n=1, c=1. SHL 0x8001 by 1 -> r=0x0002, c=1. SHR 0x0003 by 1 -> r=0x0001, c=1.
- Flags: ex_valid=1, SUB 5−5 -> next cycle zf=1. Then AND with r≠0 -> zf=0, cf unchanged. Then ex_skip_e=1 -> flags hold.
- SETC: ex_set_c=1, ex_skip_e=1 -> cf=1 next cycle. Then JC with ex_valid=1 -> jump=1. JC with ex_valid=0 -> jump=0.
- Branches: zf=0 -> JZ gives jump=0 and JMP gives jump=1. After nf set by 0x8000 MOV -> JN gives jump=1. Codes 101–111 -> jump=0.
- Reset: set all flags, assert rst for one edge -> zf=nf=cf=0. Reset and a flag update in the same cycle -> flags=0.
